mem_wb_stage: RTL and testbench

- Memory-access stage plus MEM/WB pipeline register. It sits directly downstream of the EX/MEM register and consumes that register's mem_* and mem_wt_* outputs.
- Drives a valid/ready data-memory port and stalls the upstream pipeline while an access waits.
- Registers load data, ALU result and writeback control toward the register file.

---
 rtl/mem_wb_stage_pkg.sv | 16 +
 rtl/mem_req_latch.sv | 56 +++++
 rtl/mem_wb_stage.sv | 170 +++++++++++++++++
 tb/tb_mem_wb_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_stage_pkg.sv
// Shared types and default widths for the memory-access / MEM-WB stage.
package mem_wb_stage_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  localparam int unsigned DefRegNumBitwidth = 5;
  localparam int unsigned DefWordBitwidth   = 32;

  // Byte-offset bits cleared on the data-memory address to force word alignment.
  localparam int unsigned             ByteOffBits  = 2;
  localparam logic [ByteOffBits-1:0] AlignLowBits = '0;

endpackage

// File: rtl/mem_req_latch.sv
// Holds the address, store data, direction and writeback control of an access
// that has to wait for the data memory.
module mem_req_latch #(
  parameter int unsigned REG_NUM_BITWIDTH = 5,
  parameter int unsigned WORD_BITWIDTH    = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_load,
  input  logic                        i_we,
  input  logic [WORD_BITWIDTH-1:0]    i_alu,
  input  logic [WORD_BITWIDTH-1:0]    i_wdata,
  input  logic                        i_mem_to_reg,
  input  logic                        i_reg_write,
  input  logic [REG_NUM_BITWIDTH-1:0] i_reg_to_write,
  output logic                        o_we,
  output logic [WORD_BITWIDTH-1:0]    o_alu,
  output logic [WORD_BITWIDTH-1:0]    o_wdata,
  output logic                        o_mem_to_reg,
  output logic                        o_reg_write,
  output logic [REG_NUM_BITWIDTH-1:0] o_reg_to_write
);

  logic                        r_we;
  logic [WORD_BITWIDTH-1:0]    r_alu;
  logic [WORD_BITWIDTH-1:0]    r_wdata;
  logic                        r_mem_to_reg;
  logic                        r_reg_write;
  logic [REG_NUM_BITWIDTH-1:0] r_reg_to_write;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we           <= 1'b0;
      r_alu          <= '0;
      r_wdata        <= '0;
      r_mem_to_reg   <= 1'b0;
      r_reg_write    <= 1'b0;
      r_reg_to_write <= '0;
    end else if (i_load) begin
      r_we           <= i_we;
      r_alu          <= i_alu;
      r_wdata        <= i_wdata;
      r_mem_to_reg   <= i_mem_to_reg;
      r_reg_write    <= i_reg_write;
      r_reg_to_write <= i_reg_to_write;
    end
  end

  assign o_we           = r_we;
  assign o_alu          = r_alu;
  assign o_wdata        = r_wdata;
  assign o_mem_to_reg   = r_mem_to_reg;
  assign o_reg_write    = r_reg_write;
  assign o_reg_to_write = r_reg_to_write;

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage with valid/ready data-memory handshake, upstream stall,
// access timeout and the MEM/WB pipeline register.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned REG_NUM_BITWIDTH = DefRegNumBitwidth,
  parameter int unsigned WORD_BITWIDTH    = DefWordBitwidth,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mem_memRead,
  input  logic                        mem_memWrite,
  input  logic                        mem_wt_memToReg,
  input  logic                        mem_wt_regWrite,
  input  logic [REG_NUM_BITWIDTH-1:0] mem_wt_regToWrite,
  input  logic [WORD_BITWIDTH-1:0]    mem_ALUresult,
  input  logic [WORD_BITWIDTH-1:0]    mem_readData2,
  output logic                        dmem_req,
  output logic                        dmem_we,
  output logic [WORD_BITWIDTH-1:0]    dmem_addr,
  output logic [WORD_BITWIDTH-1:0]    dmem_wdata,
  input  logic                        dmem_ready,
  input  logic [WORD_BITWIDTH-1:0]    dmem_rdata,
  output logic                        stall_out,
  output logic                        dmem_err,
  output logic                        wb_regWrite,
  output logic                        wb_memToReg,
  output logic [REG_NUM_BITWIDTH-1:0] wb_regToWrite,
  output logic [WORD_BITWIDTH-1:0]    wb_readData,
  output logic [WORD_BITWIDTH-1:0]    wb_ALUresult,
  output logic [WORD_BITWIDTH-1:0]    wb_writeData
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WORD_BITWIDTH-1:0] AddrMask =
    {{(WORD_BITWIDTH - ByteOffBits){1'b1}}, AlignLowBits};

  state_e                      r_state, w_state_next;
  logic [CntW-1:0]             r_cnt, w_cnt_next;
  logic                        r_err, w_err_next;
  logic                        r_wb_reg_write, r_wb_mem_to_reg;
  logic [REG_NUM_BITWIDTH-1:0] r_wb_reg_to_write;
  logic [WORD_BITWIDTH-1:0]    r_wb_read_data, r_wb_alu;

  logic                        w_access, w_latch_load, w_wb_load, w_sel_latch;
  logic [WORD_BITWIDTH-1:0]    w_addr_src;
  logic                        w_l_we, w_l_mem_to_reg, w_l_reg_write;
  logic [WORD_BITWIDTH-1:0]    w_l_alu, w_l_wdata;
  logic [REG_NUM_BITWIDTH-1:0] w_l_reg_to_write;

  assign w_access = mem_memRead | mem_memWrite;

  mem_req_latch #(
    .REG_NUM_BITWIDTH(REG_NUM_BITWIDTH),
    .WORD_BITWIDTH   (WORD_BITWIDTH)
  ) u_req_latch (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_load        (w_latch_load),
    .i_we          (mem_memWrite),
    .i_alu         (mem_ALUresult),
    .i_wdata       (mem_readData2),
    .i_mem_to_reg  (mem_wt_memToReg),
    .i_reg_write   (mem_wt_regWrite),
    .i_reg_to_write(mem_wt_regToWrite),
    .o_we          (w_l_we),
    .o_alu         (w_l_alu),
    .o_wdata       (w_l_wdata),
    .o_mem_to_reg  (w_l_mem_to_reg),
    .o_reg_write   (w_l_reg_write),
    .o_reg_to_write(w_l_reg_to_write)
  );

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;
    w_latch_load = 1'b0;
    w_wb_load    = 1'b0;
    w_sel_latch  = 1'b0;
    dmem_req     = 1'b0;
    stall_out    = 1'b0;
    dmem_we      = mem_memWrite;
    w_addr_src   = mem_ALUresult;
    dmem_wdata   = mem_readData2;
    unique case (r_state)
      StIdle: begin
        dmem_req = w_access;
        if (w_access && !dmem_ready) begin
          stall_out    = 1'b1;
          w_latch_load = 1'b1;
          w_cnt_next   = CntW'(1);
          w_state_next = StBusy;
        end else begin
          w_wb_load = 1'b1;
        end
      end
      StBusy: begin
        dmem_req   = 1'b1;
        dmem_we    = w_l_we;
        w_addr_src = w_l_alu;
        dmem_wdata = w_l_wdata;
        if (dmem_ready) begin
          w_wb_load    = 1'b1;
          w_sel_latch  = 1'b1;
          w_cnt_next   = '0;
          w_state_next = StIdle;
        end else if (r_cnt == CntW'(TIMEOUT_CYCLES)) begin
          // Upstream advances this cycle, so the timed-out access is dropped.
          w_err_next   = 1'b1;
          w_cnt_next   = '0;
          w_state_next = StIdle;
        end else begin
          stall_out  = 1'b1;
          w_cnt_next = r_cnt + CntW'(1);
        end
      end
      default: ;
    endcase
    if (rst) begin
      dmem_req  = 1'b0;
      stall_out = 1'b0;
    end
  end

  assign dmem_addr = w_addr_src & AddrMask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= StIdle;
      r_cnt             <= '0;
      r_err             <= 1'b0;
      r_wb_reg_write    <= 1'b0;
      r_wb_mem_to_reg   <= 1'b0;
      r_wb_reg_to_write <= '0;
      r_wb_read_data    <= '0;
      r_wb_alu          <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      if (w_wb_load && w_sel_latch) begin
        r_wb_reg_write    <= w_l_reg_write;
        r_wb_mem_to_reg   <= w_l_mem_to_reg;
        r_wb_reg_to_write <= w_l_reg_to_write;
        r_wb_alu          <= w_l_alu;
        r_wb_read_data    <= w_l_we ? '0 : dmem_rdata;
      end else if (w_wb_load) begin
        r_wb_reg_write    <= mem_wt_regWrite;
        r_wb_mem_to_reg   <= mem_wt_memToReg;
        r_wb_reg_to_write <= mem_wt_regToWrite;
        r_wb_alu          <= mem_ALUresult;
        r_wb_read_data    <= (mem_memRead && !mem_memWrite) ? dmem_rdata : '0;
      end else begin
        r_wb_reg_write  <= 1'b0;
        r_wb_mem_to_reg <= 1'b0;
      end
    end
  end

  assign dmem_err      = r_err;
  assign wb_regWrite   = r_wb_reg_write;
  assign wb_memToReg   = r_wb_mem_to_reg;
  assign wb_regToWrite = r_wb_reg_to_write;
  assign wb_readData   = r_wb_read_data;
  assign wb_ALUresult  = r_wb_alu;
  assign wb_writeData  = r_wb_mem_to_reg ? r_wb_read_data : r_wb_alu;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (timeout shortened to 4 cycles).
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        mem_memRead, mem_memWrite, mem_wt_memToReg, mem_wt_regWrite;
  logic [4:0]  mem_wt_regToWrite;
  logic [31:0] mem_ALUresult, mem_readData2;
  logic        dmem_req, dmem_we, dmem_ready, stall_out, dmem_err;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_regWrite, wb_memToReg;
  logic [4:0]  wb_regToWrite;
  logic [31:0] wb_readData, wb_ALUresult, wb_writeData;

  int n_vec;
  int n_err;

  mem_wb_stage #(
    .REG_NUM_BITWIDTH(5),
    .WORD_BITWIDTH   (32),
    .TIMEOUT_CYCLES  (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_memRead      (mem_memRead),
    .mem_memWrite     (mem_memWrite),
    .mem_wt_memToReg  (mem_wt_memToReg),
    .mem_wt_regWrite  (mem_wt_regWrite),
    .mem_wt_regToWrite(mem_wt_regToWrite),
    .mem_ALUresult    (mem_ALUresult),
    .mem_readData2    (mem_readData2),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_ready       (dmem_ready),
    .dmem_rdata       (dmem_rdata),
    .stall_out        (stall_out),
    .dmem_err         (dmem_err),
    .wb_regWrite      (wb_regWrite),
    .wb_memToReg      (wb_memToReg),
    .wb_regToWrite    (wb_regToWrite),
    .wb_readData      (wb_readData),
    .wb_ALUresult     (wb_ALUresult),
    .wb_writeData     (wb_writeData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic [4:0] dst, input logic [31:0] alu, input logic [31:0] d2,
                       input logic rdy, input logic [31:0] rdata);
    mem_memRead       = rd;
    mem_memWrite      = wr;
    mem_wt_memToReg   = m2r;
    mem_wt_regWrite   = rw;
    mem_wt_regToWrite = dst;
    mem_ALUresult     = alu;
    mem_readData2     = d2;
    dmem_ready        = rdy;
    dmem_rdata        = rdata;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h10, 32'h0, 1'b0, 32'h0);
    #1;
    n_vec++;
    if (dmem_req !== 1'b0) begin
      n_err++; $display("FAIL rst_req: got %b want 0", dmem_req);
    end
    n_vec++;
    if (stall_out !== 1'b0) begin
      n_err++; $display("FAIL rst_stall: got %b want 0", stall_out);
    end
    tick();
    tick();
    n_vec++;
    if ({wb_regWrite, wb_memToReg, wb_regToWrite} !== 7'd0) begin
      n_err++; $display("FAIL rst_wbctl: got %h want 0", {wb_regWrite, wb_memToReg, wb_regToWrite});
    end
    n_vec++;
    if (wb_writeData !== 32'd0 || wb_readData !== 32'd0 || wb_ALUresult !== 32'd0) begin
      n_err++; $display("FAIL rst_wbdata: got %h/%h/%h want 0", wb_writeData, wb_readData,
                        wb_ALUresult);
    end
    n_vec++;
    if (dmem_err !== 1'b0) begin
      n_err++; $display("FAIL rst_err: got %b want 0", dmem_err);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_zero_wait_load();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 32'h100, 32'h0, 1'b1, 32'hDEADBEEF);
    #1;
    n_vec++;
    if ({stall_out, dmem_req, dmem_we} !== 3'b010 || dmem_addr !== 32'h100) begin
      n_err++; $display("FAIL zw_bus: got stall/req/we=%b addr=%h want 010 100",
                        {stall_out, dmem_req, dmem_we}, dmem_addr);
    end
    tick();
    n_vec++;
    if (wb_readData !== 32'hDEADBEEF || wb_writeData !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL zw_data: got %h/%h want deadbeef", wb_readData, wb_writeData);
    end
    n_vec++;
    if (wb_regToWrite !== 5'd5 || wb_regWrite !== 1'b1) begin
      n_err++; $display("FAIL zw_ctl: got rd=%0d rw=%b want 5 1", wb_regToWrite, wb_regWrite);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_wait_load();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h204, 32'h0, 1'b0, 32'hBAD);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (stall_out !== 1'b1 || dmem_req !== 1'b1 || dmem_addr !== 32'h204) begin
        n_err++; $display("FAIL ws_stall%0d: got stall=%b req=%b addr=%h want 1 1 204", i,
                          stall_out, dmem_req, dmem_addr);
      end
      tick();
      n_vec++;
      if (wb_regWrite !== 1'b0) begin
        n_err++; $display("FAIL ws_bubble%0d: got %b want 0", i, wb_regWrite);
      end
      // Scramble the inputs: the bus must now come from the captured request.
      if (i == 0) drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h999, 32'h0, 1'b0, 32'hBAD);
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'h1234;
    #1;
    n_vec++;
    if (stall_out !== 1'b0 || dmem_req !== 1'b1 || dmem_addr !== 32'h204) begin
      n_err++; $display("FAIL ws_done: got stall=%b req=%b addr=%h want 0 1 204", stall_out,
                        dmem_req, dmem_addr);
    end
    tick();
    n_vec++;
    if (wb_readData !== 32'h1234 || wb_writeData !== 32'h1234 || wb_ALUresult !== 32'h204) begin
      n_err++; $display("FAIL ws_data: got %h/%h/%h want 1234 1234 204", wb_readData,
                        wb_writeData, wb_ALUresult);
    end
    n_vec++;
    if (wb_regWrite !== 1'b1 || wb_regToWrite !== 5'd7) begin
      n_err++; $display("FAIL ws_ctl: got rw=%b rd=%0d want 1 7", wb_regWrite, wb_regToWrite);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_store();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 32'h103, 32'hA5A5A5A5, 1'b1, 32'hFFFF0000);
    #1;
    n_vec++;
    if (dmem_we !== 1'b1 || dmem_addr !== 32'h100 || dmem_wdata !== 32'hA5A5A5A5) begin
      n_err++; $display("FAIL st_bus: got we=%b addr=%h wdata=%h want 1 100 a5a5a5a5",
                        dmem_we, dmem_addr, dmem_wdata);
    end
    tick();
    n_vec++;
    if (wb_readData !== 32'd0 || wb_writeData !== 32'h103) begin
      n_err++; $display("FAIL st_wb: got rdata=%h wdata=%h want 0 103", wb_readData,
                        wb_writeData);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_non_mem();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h77, 32'h0, 1'b1, 32'hCAFE);
    #1;
    n_vec++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin
      n_err++; $display("FAIL nm_bus: got req=%b stall=%b want 0 0", dmem_req, stall_out);
    end
    tick();
    n_vec++;
    if (wb_writeData !== 32'h77 || wb_readData !== 32'd0 || wb_regWrite !== 1'b1) begin
      n_err++; $display("FAIL nm_wb: got wdata=%h rdata=%h rw=%b want 77 0 1", wb_writeData,
                        wb_readData, wb_regWrite);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 32'h10, 32'h0, 1'b1, 32'h11111111);
    tick();
    n_vec++;
    if (wb_writeData !== 32'h11111111 || wb_regToWrite !== 5'd1) begin
      n_err++; $display("FAIL b2b_first: got %h rd=%0d want 11111111 1", wb_writeData,
                        wb_regToWrite);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 32'h14, 32'h0, 1'b1, 32'h22222222);
    tick();
    n_vec++;
    if (wb_writeData !== 32'h22222222 || wb_regToWrite !== 5'd2) begin
      n_err++; $display("FAIL b2b_second: got %h rd=%0d want 22222222 2", wb_writeData,
                        wb_regToWrite);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_timeout();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 32'h40, 32'h5, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (stall_out !== 1'b1) begin
        n_err++; $display("FAIL to_stall%0d: got %b want 1", i, stall_out);
      end
      tick();
    end
    #1;
    n_vec++;
    if (stall_out !== 1'b0 || dmem_req !== 1'b1 || dmem_err !== 1'b0) begin
      n_err++; $display("FAIL to_last: got stall=%b req=%b err=%b want 0 1 0", stall_out,
                        dmem_req, dmem_err);
    end
    tick();
    n_vec++;
    if (dmem_err !== 1'b1 || wb_regWrite !== 1'b0) begin
      n_err++; $display("FAIL to_err: got err=%b rw=%b want 1 0", dmem_err, wb_regWrite);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 32'h80, 32'h0, 1'b1, 32'h5A);
    #1;
    n_vec++;
    if (stall_out !== 1'b0 || dmem_addr !== 32'h80) begin
      n_err++; $display("FAIL to_idle: got stall=%b addr=%h want 0 80", stall_out, dmem_addr);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
    tick();
    n_vec++;
    if (dmem_err !== 1'b1) begin
      n_err++; $display("FAIL to_sticky: got %b want 1", dmem_err);
    end
  endtask

  task automatic test_reset_busy();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'h55, 32'h0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h300, 32'h0, 1'b0, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    n_vec++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin
      n_err++; $display("FAIL rb_force: got req=%b stall=%b want 0 0", dmem_req, stall_out);
    end
    n_vec++;
    if (wb_ALUresult !== 32'h55 || wb_regWrite !== 1'b0) begin
      n_err++; $display("FAIL rb_hold: got alu=%h rw=%b want 55 0", wb_ALUresult, wb_regWrite);
    end
    tick();
    rst = 1'b0;
    n_vec++;
    if (wb_ALUresult !== 32'd0 || wb_readData !== 32'd0 || wb_regToWrite !== 5'd0 ||
        dmem_err !== 1'b0) begin
      n_err++; $display("FAIL rb_clear: got alu=%h rdata=%h rd=%0d err=%b want 0 0 0 0",
                        wb_ALUresult, wb_readData, wb_regToWrite, dmem_err);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 32'h408, 32'h0, 1'b1, 32'h77);
    #1;
    n_vec++;
    if (stall_out !== 1'b0 || dmem_addr !== 32'h408 || dmem_req !== 1'b1) begin
      n_err++; $display("FAIL rb_idle: got stall=%b addr=%h req=%b want 0 408 1", stall_out,
                        dmem_addr, dmem_req);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    test_reset();
    test_zero_wait_load();
    test_wait_load();
    test_store();
    test_non_mem();
    test_back_to_back();
    test_timeout();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
